// File: rtl/ram_clr_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ram_clr_pkg
//  Purpose : Shared definitions for the clearable RAM: clear-engine state
//            encoding and the bit-cast helper used for address range checks.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package ram_clr_pkg;

    // One-bit state encoding for the clear engine.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Width of the (AW+1)-bit range comparisons. One extra bit lets DEPTH
    // reach 2**AW without wrapping to zero.
    localparam int c_RANGE_PAD = 1;

endpackage : ram_clr_pkg
`default_nettype wire

// File: rtl/ram_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : ram_clear_ctrl
//  Purpose : Clear engine for ram_clr. Holds the IDLE/CLEAR state and a sweep
//            pointer that walks 0..DEPTH-1, emitting one zero-write per cycle.
//  Ports   : clk      - clock
//            reset    - synchronous active-high; (re)starts a full sweep
//            clr      - clear request, honoured only in IDLE
//            busy     - 1 while sweeping or while reset is held
//            clr_we   - zero-write strobe for the memory this cycle
//            clr_addr - word address of the zero-write
//  Rev     : 1.0  initial release
// ============================================================================
module ram_clear_ctrl
    import ram_clr_pkg::*;
#(
    parameter int DEPTH = 3840,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_ONE  = AW'(1);

    clr_state_e    r_state;
    clr_state_e    w_next_state;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_next_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (clr) begin
                    w_next_state = ST_CLEAR;
                    w_next_ptr   = '0;
                end
            end
            ST_CLEAR: begin
                // clr is deliberately ignored here; the sweep always runs to
                // completion unless reset restarts it.
                w_next_ptr = r_ptr + c_ONE;
                if (r_ptr == c_LAST) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_ptr   = '0;
            end
        endcase
    end

    // reset is folded into busy so the memory reads zero and rejects writes
    // on the very cycle reset is applied. No zero-write happens on that edge.
    assign busy     = (r_state == ST_CLEAR) | reset;
    assign clr_we   = (r_state == ST_CLEAR) & ~reset;
    assign clr_addr = r_ptr;

endmodule : ram_clear_ctrl
`default_nettype wire

// File: rtl/ram_clr.sv
`default_nettype none
// ============================================================================
//  Module  : ram_clr
//  Purpose : Single-port WIDTH x DEPTH RAM with a hardware clear engine.
//            Reads are combinational; writes land on posedge. Contents are
//            zeroed by a DEPTH-cycle sweep after reset or a clr request.
//  Ports   : clk     - clock
//            reset   - synchronous active-high; starts a full clear
//            clr     - clear request (single-cycle pulse is enough)
//            address - read/write word address
//            in      - write data
//            load    - write enable
//            out     - mem[address], or 0 when busy / address out of range
//            busy    - 1 while the clear engine is sweeping
//  Rev     : 1.0  initial release
// ============================================================================
module ram_clr
    import ram_clr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3840,
    parameter int AW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [AW-1:0]    address,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam int              c_RW    = AW + c_RANGE_PAD;
    localparam logic [c_RW-1:0] c_DEPTH = c_RW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic          w_clr_we;
    logic [AW-1:0] w_clr_addr;
    logic          w_in_range;
    logic          w_wr_ok;

    ram_clear_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign w_in_range = ({1'b0, address} < c_DEPTH);

    // A user write needs an idle engine and no clear starting on this edge;
    // busy already covers reset.
    assign w_wr_ok = load & w_in_range & ~busy & ~clr;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[address] <= in;
        end
    end

    assign out = (busy | ~w_in_range) ? '0 : r_mem[address];

endmodule : ram_clr
`default_nettype wire

// File: tb/tb_ram_clr.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ram_clr
//  Purpose : Self-checking bench for ram_clr. A behavioural model tracks the
//            memory contents and the number of busy cycles left; outputs are
//            compared against it on every negedge, plus literal spot checks.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_ram_clr;

    localparam int WIDTH = 16;
    localparam int DEPTH = 3840;
    localparam int AW    = 12;

    logic             clk;
    logic             reset;
    logic             clr;
    logic [AW-1:0]    address;
    logic [WIDTH-1:0] in;
    logic             load;
    logic [WIDTH-1:0] out;
    logic             busy;

    int total = 0;
    int bad   = 0;

    ram_clr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .address (address),
        .in      (in),
        .load    (load),
        .out     (out),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // A clear is modelled as an instant wipe plus DEPTH busy cycles: the
    // outputs are masked during the sweep, so the gradual order is invisible.
    logic [WIDTH-1:0] m_mem [DEPTH];
    int               m_rem   = 0;
    bit               m_valid = 1'b0;

    task automatic m_wipe();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_rem = DEPTH;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_wipe();
        end else if (m_valid) begin
            if (m_rem > 0)                           m_rem = m_rem - 1;
            else if (clr)                            m_wipe();
            else if (load && int'(address) < DEPTH)  m_mem[address] = in;
        end
    end

    function automatic logic [WIDTH-1:0] m_out();
        if (reset || m_rem > 0 || int'(address) >= DEPTH) return '0;
        return m_mem[address];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("busy_cyc", 32'(busy), 32'(reset || m_rem > 0));
            check("out_cyc", 32'(out), 32'(m_out()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(string name, input int exp_len);
        int n = 0;
        while (busy === 1'b1 && n < DEPTH + 200) begin
            n++;
            tick();
        end
        check(name, 32'(n), 32'(exp_len));
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while (busy !== 1'b0 && n < DEPTH + 10) begin
            n++;
            tick();
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        address = a; in = d; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic peek(string name, input logic [AW-1:0] a, input logic [WIDTH-1:0] exp);
        address = a;
        #1;
        check(name, 32'(out), 32'(exp));
    endtask

    task automatic scan(string name);
        for (int a = 0; a < DEPTH; a++) begin
            address = AW'(a);
            #1;
            check(name, 32'(out), 32'(m_mem[a]));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [WIDTH-1:0] d;
        reset = 1'b1; clr = 1'b0; load = 1'b0; address = '0; in = '0;
        #1;
        check("busy_in_reset", 32'(busy), 32'd1);
        check("out_in_reset", 32'(out), 32'd0);
        tick();
        reset = 1'b0;

        // Full sweep length after reset, then all-zero memory.
        count_busy("reset_sweep_len", DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            address = AW'(a);
            #1;
            check("zero_after_reset", 32'(out), 32'd0);
        end

        // Read-after-write at the top address and both ends.
        write(12'h0EFF, 16'hBEEF);
        peek("wb_beef", 12'h0EFF, 16'hBEEF);
        d = WIDTH'($urandom);
        write(12'h000, d);
        peek("wb_addr0", 12'h000, m_mem[0]);
        d = WIDTH'($urandom);
        write(12'hEFF, d);
        peek("wb_addr3839", 12'hEFF, m_mem[DEPTH-1]);

        // Out-of-range write is dropped and reads zero.
        write(12'hF00, 16'h1234);
        peek("oor_read", 12'hF00, 16'h0000);
        peek("oor_max", 12'hFFF, 16'h0000);
        scan("oor_unchanged");

        // Busy lockout: writes to address 5 during the sweep are lost.
        write(12'd5, 16'h1111);
        peek("pre_lock", 12'd5, 16'h1111);
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            address = 12'd5; in = 16'hAAAA; load = 1'b1;
            tick();
        end
        load = 1'b0;
        wait_idle("lock_idle");
        peek("lock_addr5", 12'd5, 16'h0000);

        // Reset when the sweep pointer has reached 100.
        write(12'd9, 16'h7777);
        peek("pre_midreset", 12'd9, 16'h7777);
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (100) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        count_busy("midreset_len", DEPTH);
        peek("midreset_addr9", 12'd9, 16'h0000);

        // load and clr on the same edge: write dropped.
        write(12'd7, 16'h3333);
        address = 12'd7; in = 16'h5555; load = 1'b1; clr = 1'b1;
        tick();
        load = 1'b0; clr = 1'b0;
        wait_idle("simul_idle");
        peek("simul_addr7", 12'd7, 16'h0000);

        // Randomised traffic, including rare clears and resets.
        for (int i = 0; i < 6000; i++) begin
            address = AW'($urandom);
            if ($urandom_range(0, 3) != 0) address = AW'($urandom_range(0, 31));
            in    = WIDTH'($urandom);
            load  = ($urandom_range(0, 1) == 1);
            clr   = ($urandom_range(0, 1999) == 0);
            reset = ($urandom_range(0, 3999) == 0);
            tick();
        end
        reset = 1'b0; clr = 1'b0; load = 1'b0;
        wait_idle("rand_idle");
        scan("rand_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_ram_clr
`default_nettype wire
